// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the BP memory-end stream blocks.
package bp_me_pkg;

  // Arbiter state: IDLE arbitrates per message, BUSY holds a locked grant.
  typedef enum logic [0:0] {
    e_stream_arb_idle = 1'b0,
    e_stream_arb_busy = 1'b1
  } stream_arb_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int bp_me_clog2(input int n);
    int r;
    r = $clog2(n);
    if (r < 1) begin
      return 1;
    end else begin
      return r;
    end
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin grant logic with a rotating priority pointer. While hold_v_i is
// high the grant is forced to hold_id_i so a locked message keeps its source;
// yumi_i consumes the current grant and moves the pointer just past it.
module bsg_arb_round_robin
  import bp_me_pkg::*;
#(
  parameter  int width_p     = 4,
  localparam int lg_width_lp = bp_me_clog2(width_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [width_p-1:0]     reqs_i,
  input  logic                   hold_v_i,
  input  logic [lg_width_lp-1:0] hold_id_i,
  input  logic                   yumi_i,
  output logic [width_p-1:0]     grants_o,
  output logic [lg_width_lp-1:0] grant_id_o
);

  logic [lg_width_lp-1:0] ptr_r;
  logic [lg_width_lp:0]   idx_s;
  logic [lg_width_lp-1:0] idx_lo_s;
  logic                   found_s;

  // Search for the first request at or after the pointer, wrapping around.
  always_comb begin
    grant_id_o = ptr_r;
    found_s    = 1'b0;
    idx_s      = {(lg_width_lp+1){1'b0}};
    idx_lo_s   = {lg_width_lp{1'b0}};
    for (int i = 0; i < width_p; i++) begin
      idx_s = {1'b0, ptr_r} + (lg_width_lp+1)'(i);
      if (idx_s >= (lg_width_lp+1)'(width_p)) begin
        idx_s = idx_s - (lg_width_lp+1)'(width_p);
      end else begin
        idx_s = idx_s;
      end
      idx_lo_s = idx_s[lg_width_lp-1:0];
      if (!found_s && reqs_i[idx_lo_s]) begin
        found_s    = 1'b1;
        grant_id_o = idx_lo_s;
      end else begin
        found_s = found_s;
      end
    end
    if (hold_v_i) begin
      grant_id_o = hold_id_i;
    end else begin
      grant_id_o = grant_id_o;
    end
  end

  // One-hot grant; empty when idle with nothing requesting.
  always_comb begin
    for (int i = 0; i < width_p; i++) begin
      grants_o[i] = (grant_id_o == lg_width_lp'(i)) & (hold_v_i | found_s);
    end
  end

  // Advance the priority pointer past each consumed grant.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ptr_r <= {lg_width_lp{1'b0}};
    end else if (yumi_i) begin
      if (grant_id_o == lg_width_lp'(width_p-1)) begin
        ptr_r <= {lg_width_lp{1'b0}};
      end else begin
        ptr_r <= grant_id_o + lg_width_lp'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/bsg_mux_one_hot.sv
// AND-OR multiplexer driven by a one-hot select; an all-zero select yields zero.
module bsg_mux_one_hot #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic [els_p*width_p-1:0] data_i,
  input  logic [els_p-1:0]         sel_one_hot_i,
  output logic [width_p-1:0]       data_o
);

  // OR together every slice whose select bit is set.
  always_comb begin
    data_o = {width_p{1'b0}};
    for (int i = 0; i < els_p; i++) begin
      data_o = data_o | (data_i[i*width_p +: width_p] & {width_p{sel_one_hot_i[i]}});
    end
  end

endmodule

// File: rtl/bp_me_stream_arbiter.sv
// Round-robin arbiter sharing one BP stream channel between num_src_p masters.
// A message whose first beat carries lock=1 keeps the grant until its lock=0
// beat, so multi-beat messages arrive contiguously. The beat path is purely
// combinational. Optional watchdog: define BP_ME_STREAM_ARB_WATCHDOG_EN to flag
// (sticky err_o) locked messages that exceed max_beats_p beats.
module bp_me_stream_arbiter
  import bp_me_pkg::*;
#(
  parameter  int num_src_p      = 4,
  parameter  int header_width_p = 72,
  parameter  int data_width_p   = 64,
  parameter  int max_beats_p    = 8,
  localparam int lg_num_src_lp  = bp_me_clog2(num_src_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_src_p*header_width_p-1:0] src_header_i,
  input  logic [num_src_p*data_width_p-1:0]   src_data_i,
  input  logic [num_src_p-1:0]                src_v_i,
  output logic [num_src_p-1:0]                src_ready_o,
  input  logic [num_src_p-1:0]                src_lock_i,
  output logic [header_width_p-1:0]           dst_header_o,
  output logic [data_width_p-1:0]             dst_data_o,
  output logic                                dst_v_o,
  input  logic                                dst_ready_i,
  output logic                                dst_lock_o,
  output logic [lg_num_src_lp-1:0]            grant_id_o,
  output logic                                err_o
);

  stream_arb_state_e        state_r, state_n_s;
  logic [lg_num_src_lp-1:0] lock_id_r, lock_id_n_s;
  logic [lg_num_src_lp-1:0] grant_id_s;
  logic [num_src_p-1:0]     grant_oh_s;
  logic                     busy_s, dst_v_s, dst_lock_s, xfer_s, yumi_s;

  assign busy_s = (state_r == e_stream_arb_busy);

  bsg_arb_round_robin #(.width_p(num_src_p)) rr_arb (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .reqs_i     (src_v_i),
    .hold_v_i   (busy_s),
    .hold_id_i  (lock_id_r),
    .yumi_i     (yumi_s),
    .grants_o   (grant_oh_s),
    .grant_id_o (grant_id_s)
  );

  bsg_mux_one_hot #(.width_p(header_width_p), .els_p(num_src_p)) header_mux (
    .data_i        (src_header_i),
    .sel_one_hot_i (grant_oh_s),
    .data_o        (dst_header_o)
  );

  bsg_mux_one_hot #(.width_p(data_width_p), .els_p(num_src_p)) data_mux (
    .data_i        (src_data_i),
    .sel_one_hot_i (grant_oh_s),
    .data_o        (dst_data_o)
  );

  // Handshake: forward the granted source's valid/lock; reset blocks both directions.
  always_comb begin
    dst_v_s    = reset_n_i & src_v_i[grant_id_s];
    dst_lock_s = src_lock_i[grant_id_s];
    xfer_s     = dst_v_s & dst_ready_i;
    // the pointer only moves when a message completes (single beat or last beat)
    yumi_s     = xfer_s & ~dst_lock_s;
    if (reset_n_i && dst_ready_i) begin
      src_ready_o = grant_oh_s;
    end else begin
      src_ready_o = {num_src_p{1'b0}};
    end
  end

  assign dst_v_o    = dst_v_s;
  assign dst_lock_o = dst_lock_s;
  assign grant_id_o = grant_id_s;

  // Next state: lock on a locked first beat, release on the lock=0 beat.
  always_comb begin
    state_n_s   = state_r;
    lock_id_n_s = lock_id_r;
    case (state_r)
      e_stream_arb_idle: begin
        if (xfer_s && dst_lock_s) begin
          state_n_s   = e_stream_arb_busy;
          lock_id_n_s = grant_id_s;
        end else begin
          state_n_s = e_stream_arb_idle;
        end
      end
      e_stream_arb_busy: begin
        if (xfer_s && !dst_lock_s) begin
          state_n_s = e_stream_arb_idle;
        end else begin
          state_n_s = e_stream_arb_busy;
        end
      end
      default: begin
        state_n_s = e_stream_arb_idle;
      end
    endcase
  end

  // State and latched grant registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r   <= e_stream_arb_idle;
      lock_id_r <= {lg_num_src_lp{1'b0}};
    end else begin
      state_r   <= state_n_s;
      lock_id_r <= lock_id_n_s;
    end
  end

`ifdef BP_ME_STREAM_ARB_WATCHDOG_EN
  localparam int cnt_width_lp = bp_me_clog2(max_beats_p + 2);

  logic [cnt_width_lp-1:0] beat_cnt_r, beat_cnt_n_s;
  logic                    err_r, err_n_s;

  // Count beats of the locked message; an overlong locked message sets the sticky error.
  always_comb begin
    beat_cnt_n_s = beat_cnt_r;
    err_n_s      = err_r;
    if (xfer_s && !busy_s) begin
      beat_cnt_n_s = dst_lock_s ? cnt_width_lp'(1) : cnt_width_lp'(0);
    end else if (xfer_s && dst_lock_s) begin
      if (beat_cnt_r >= cnt_width_lp'(max_beats_p)) begin
        err_n_s = 1'b1;
      end else begin
        err_n_s = err_r;
      end
      if (beat_cnt_r < cnt_width_lp'(max_beats_p + 1)) begin
        beat_cnt_n_s = beat_cnt_r + cnt_width_lp'(1);
      end else begin
        beat_cnt_n_s = beat_cnt_r;
      end
    end else if (xfer_s) begin
      beat_cnt_n_s = cnt_width_lp'(0);
    end else begin
      beat_cnt_n_s = beat_cnt_r;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      beat_cnt_r <= cnt_width_lp'(0);
      err_r      <= 1'b0;
    end else begin
      beat_cnt_r <= beat_cnt_n_s;
      err_r      <= err_n_s;
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_me_stream_arbiter.sv
// Directed testbench for bp_me_stream_arbiter (4 sources, 72-bit header, 64-bit data).
module tb_bp_me_stream_arbiter;

  localparam int NS = 4;
  localparam int HW = 72;
  localparam int DW = 64;
  localparam int MB = 8;
`ifdef BP_ME_STREAM_ARB_WATCHDOG_EN
  localparam logic WD_ON = 1'b1;
`else
  localparam logic WD_ON = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic [NS*HW-1:0] src_header_i;
  logic [NS*DW-1:0] src_data_i;
  logic [NS-1:0]    src_v_i;
  logic [NS-1:0]    src_ready_o;
  logic [NS-1:0]    src_lock_i;
  logic [HW-1:0]    dst_header_o;
  logic [DW-1:0]    dst_data_o;
  logic             dst_v_o;
  logic             dst_ready_i;
  logic             dst_lock_o;
  logic [1:0]       grant_id_o;
  logic             err_o;

  int n_cmp = 0;
  int n_err = 0;

  bp_me_stream_arbiter #(
    .num_src_p(NS), .header_width_p(HW), .data_width_p(DW), .max_beats_p(MB)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .src_header_i(src_header_i), .src_data_i(src_data_i),
    .src_v_i(src_v_i), .src_ready_o(src_ready_o), .src_lock_i(src_lock_i),
    .dst_header_o(dst_header_o), .dst_data_o(dst_data_o), .dst_v_o(dst_v_o),
    .dst_ready_i(dst_ready_i), .dst_lock_o(dst_lock_o),
    .grant_id_o(grant_id_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [HW-1:0] hdr_of(input int i);
    return {8'hA0 + 8'(i), 64'h0123_4567_89AB_CD00 + 64'(i)};
  endfunction

  function automatic logic [DW-1:0] dat_of(input int i, input int b);
    return {32'hD000_0000 + 32'(i), 32'(b)};
  endfunction

  task automatic set_src(input int i, input logic v, input logic lk, input int b);
    src_v_i[i]              = v;
    src_lock_i[i]           = lk;
    src_header_i[i*HW +: HW] = hdr_of(i);
    src_data_i[i*DW +: DW]   = dat_of(i, b);
  endtask

  task automatic clr_all();
    for (int i = 0; i < NS; i++) set_src(i, 1'b0, 1'b0, 0);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_n_i   = 1'b0;
    dst_ready_i = 1'b1;
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 1'b0, 0);
    cyc(); cyc(); cyc();
    #1;
    n_cmp++;
    if ({dst_v_o, src_ready_o, err_o} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b ready=%b err=%b, want 0/0000/0", dst_v_o, src_ready_o, err_o);
    end
    reset_n_i = 1'b1;
    #1;
    n_cmp++;
    if ({dst_v_o, grant_id_o, src_ready_o} !== {1'b1, 2'd0, 4'b0001} || dst_header_o !== hdr_of(0)) begin
      n_err++;
      $display("FAIL first_grant: got v=%b g=%0d ready=%b hdr=%h, want 1/0/0001/%h",
               dst_v_o, grant_id_o, src_ready_o, dst_header_o, hdr_of(0));
    end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if ({dst_v_o, grant_id_o} !== {1'b1, 2'(k % 4)} || dst_data_o !== dat_of(k % 4, 0)) begin
        n_err++;
        $display("FAIL rr_seq[%0d]: got v=%b g=%0d data=%h, want 1/%0d/%h",
                 k, dst_v_o, grant_id_o, dst_data_o, k % 4, dat_of(k % 4, 0));
      end
      cyc();
    end
    // pointer is now 1; only source 3 valid -> search wraps to 3
    clr_all();
    set_src(3, 1'b1, 1'b0, 0);
    #1;
    n_cmp++;
    if ({dst_v_o, grant_id_o, src_ready_o} !== {1'b1, 2'd3, 4'b1000}) begin
      n_err++;
      $display("FAIL rr_wrap: got v=%b g=%0d ready=%b, want 1/3/1000", dst_v_o, grant_id_o, src_ready_o);
    end
    cyc();
    clr_all();
  endtask

  task automatic test_lock_hold();
    set_src(1, 1'b1, 1'b0, 0);
    for (int b = 0; b < 4; b++) begin
      set_src(0, 1'b1, (b < 3), b);
      #1;
      n_cmp++;
      if ({dst_v_o, grant_id_o, src_ready_o, dst_lock_o} !== {1'b1, 2'd0, 4'b0001, (b < 3)} ||
          dst_data_o !== dat_of(0, b)) begin
        n_err++;
        $display("FAIL lock_beat[%0d]: got v=%b g=%0d ready=%b lock=%b data=%h, want 1/0/0001/%b/%h",
                 b, dst_v_o, grant_id_o, src_ready_o, dst_lock_o, dst_data_o, (b < 3), dat_of(0, b));
      end
      cyc();
    end
    set_src(0, 1'b0, 1'b0, 0);
    #1;
    n_cmp++;
    if ({dst_v_o, grant_id_o, src_ready_o} !== {1'b1, 2'd1, 4'b0010}) begin
      n_err++;
      $display("FAIL lock_after: got v=%b g=%0d ready=%b, want 1/1/0010", dst_v_o, grant_id_o, src_ready_o);
    end
    cyc();
    clr_all();
  endtask

  task automatic test_bubble();
    set_src(3, 1'b1, 1'b0, 0);
    set_src(2, 1'b1, 1'b1, 0);
    #1;
    n_cmp++;
    if ({dst_v_o, grant_id_o, src_ready_o} !== {1'b1, 2'd2, 4'b0100}) begin
      n_err++;
      $display("FAIL bubble_first: got v=%b g=%0d ready=%b, want 1/2/0100", dst_v_o, grant_id_o, src_ready_o);
    end
    cyc();
    set_src(2, 1'b0, 1'b1, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if ({dst_v_o, grant_id_o, src_ready_o[3]} !== {1'b0, 2'd2, 1'b0}) begin
        n_err++;
        $display("FAIL bubble_hold[%0d]: got v=%b g=%0d ready3=%b, want 0/2/0", k, dst_v_o, grant_id_o, src_ready_o[3]);
      end
      cyc();
    end
    set_src(2, 1'b1, 1'b0, 1);
    #1;
    n_cmp++;
    if ({dst_v_o, grant_id_o, src_ready_o} !== {1'b1, 2'd2, 4'b0100} || dst_data_o !== dat_of(2, 1)) begin
      n_err++;
      $display("FAIL bubble_last: got v=%b g=%0d ready=%b data=%h, want 1/2/0100/%h",
               dst_v_o, grant_id_o, src_ready_o, dst_data_o, dat_of(2, 1));
    end
    cyc();
    set_src(2, 1'b0, 1'b0, 0);
    #1;
    n_cmp++;
    if ({dst_v_o, grant_id_o, src_ready_o} !== {1'b1, 2'd3, 4'b1000}) begin
      n_err++;
      $display("FAIL bubble_next: got v=%b g=%0d ready=%b, want 1/3/1000", dst_v_o, grant_id_o, src_ready_o);
    end
    cyc();
    clr_all();
  endtask

  task automatic test_backpressure();
    dst_ready_i = 1'b0;
    set_src(1, 1'b1, 1'b0, 7);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if ({dst_v_o, grant_id_o, src_ready_o} !== {1'b1, 2'd1, 4'b0000} ||
          dst_header_o !== hdr_of(1) || dst_data_o !== dat_of(1, 7)) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: got v=%b g=%0d ready=%b hdr=%h data=%h, want 1/1/0000/%h/%h",
                 k, dst_v_o, grant_id_o, src_ready_o, dst_header_o, dst_data_o, hdr_of(1), dat_of(1, 7));
      end
      cyc();
    end
    // pointer must still be 0, so source 0 wins over source 1
    dst_ready_i = 1'b1;
    set_src(0, 1'b1, 1'b0, 0);
    #1;
    n_cmp++;
    if ({dst_v_o, grant_id_o, src_ready_o} !== {1'b1, 2'd0, 4'b0001}) begin
      n_err++;
      $display("FAIL bp_ptr: got v=%b g=%0d ready=%b, want 1/0/0001", dst_v_o, grant_id_o, src_ready_o);
    end
    cyc();
    set_src(0, 1'b0, 1'b0, 0);
    #1;
    n_cmp++;
    if ({dst_v_o, grant_id_o, src_ready_o} !== {1'b1, 2'd1, 4'b0010} || dst_data_o !== dat_of(1, 7)) begin
      n_err++;
      $display("FAIL bp_release: got v=%b g=%0d ready=%b data=%h, want 1/1/0010/%h",
               dst_v_o, grant_id_o, src_ready_o, dst_data_o, dat_of(1, 7));
    end
    cyc();
    clr_all();
  endtask

  task automatic test_idle();
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if ({dst_v_o, grant_id_o, src_ready_o} !== {1'b0, 2'd2, 4'b0000}) begin
        n_err++;
        $display("FAIL idle[%0d]: got v=%b g=%0d ready=%b, want 0/2/0000", k, dst_v_o, grant_id_o, src_ready_o);
      end
      cyc();
    end
  endtask

  task automatic test_watchdog();
    for (int b = 0; b < 9; b++) begin
      set_src(2, 1'b1, 1'b1, b);
      #1;
      n_cmp++;
      if ({dst_v_o, grant_id_o, err_o} !== {1'b1, 2'd2, 1'b0}) begin
        n_err++;
        $display("FAIL wd_beat[%0d]: got v=%b g=%0d err=%b, want 1/2/0", b, dst_v_o, grant_id_o, err_o);
      end
      cyc();
    end
    set_src(2, 1'b1, 1'b0, 9);
    #1;
    n_cmp++;
    if (err_o !== WD_ON) begin
      n_err++;
      $display("FAIL wd_err_rise: got err=%b, want %b", err_o, WD_ON);
    end
    cyc();
    set_src(2, 1'b0, 1'b0, 0);
    set_src(3, 1'b1, 1'b0, 0);
    #1;
    n_cmp++;
    if ({err_o, dst_v_o, grant_id_o} !== {WD_ON, 1'b1, 2'd3}) begin
      n_err++;
      $display("FAIL wd_sticky: got err=%b v=%b g=%0d, want %b/1/3", err_o, dst_v_o, grant_id_o, WD_ON);
    end
    cyc();
    clr_all();
    #1;
    n_cmp++;
    if (err_o !== WD_ON) begin
      n_err++;
      $display("FAIL wd_sticky_idle: got err=%b, want %b", err_o, WD_ON);
    end
  endtask

  initial begin
    reset_n_i    = 1'b0;
    dst_ready_i  = 1'b0;
    src_header_i = '0;
    src_data_i   = '0;
    src_v_i      = '0;
    src_lock_i   = '0;
    test_reset();
    test_round_robin();
    test_lock_hold();
    test_bubble();
    test_backpressure();
    test_idle();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
